// File: rtl/sliding_ray_scanner_if.sv
// Request/result handshake and board read port of the sliding-piece ray scanner.
// res_king_hit exists only when SCAN_KING_HIT_EN is defined.
interface sliding_ray_scanner_if #(
    parameter int BOARD_N = 8
) ();
    localparam int CW = $clog2(BOARD_N);

    logic              req_valid;
    logic              req_ready;
    logic [CW-1:0]     req_row;
    logic [CW-1:0]     req_col;
    logic              req_color;
    logic [1:0]        req_mode;
    logic              sq_rd_en;
    logic [CW-1:0]     sq_row;
    logic [CW-1:0]     sq_col;
    logic [4:0]        sq_data;
    logic              res_valid;
    logic              res_ready;
    logic [8*CW-1:0]   res_dist;
    logic [7:0]        res_capture;
`ifdef SCAN_KING_HIT_EN
    logic [7:0]        res_king_hit;

    modport master (
        output req_valid, req_row, req_col, req_color, req_mode,
        output res_ready, sq_data,
        input  req_ready, sq_rd_en, sq_row, sq_col,
        input  res_valid, res_dist, res_capture, res_king_hit
    );

    modport slave (
        input  req_valid, req_row, req_col, req_color, req_mode,
        input  res_ready, sq_data,
        output req_ready, sq_rd_en, sq_row, sq_col,
        output res_valid, res_dist, res_capture, res_king_hit
    );
`else
    modport master (
        output req_valid, req_row, req_col, req_color, req_mode,
        output res_ready, sq_data,
        input  req_ready, sq_rd_en, sq_row, sq_col,
        input  res_valid, res_dist, res_capture
    );

    modport slave (
        input  req_valid, req_row, req_col, req_color, req_mode,
        input  res_ready, sq_data,
        output req_ready, sq_rd_en, sq_row, sq_col,
        output res_valid, res_dist, res_capture
    );
`endif
endinterface

// File: rtl/sliding_ray_scanner.sv
// Sequential move-range engine for bishop/rook/queen rays over a 1-cycle board RAM.
// Optional SCAN_KING_HIT_EN adds res_king_hit (opponent king captured per ray).
module sliding_ray_scanner #(
    parameter int  BOARD_N = 8,
    localparam int CW      = $clog2(BOARD_N)
) (
    input logic                  clk,
    input logic                  rst_n,
    sliding_ray_scanner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, WAIT, DONE} state_t;

    localparam logic signed [CW+1:0] MAXC = (CW+2)'(BOARD_N - 1);
    localparam logic [CW:0]          ONE  = (CW+1)'(1);

    state_t state, state_d;

    logic [CW-1:0] row_q, col_q;
    logic [CW-1:0] lrow_q, lcol_q;
    logic          color_q;
    logic [1:0]    mode_q;
    logic [2:0]    k_q;
    logic [CW:0]   i_q;
    logic [CW-1:0] dist_q [8];
    logic [7:0]    cap_q;
`ifdef SCAN_KING_HIT_EN
    logic [7:0]    kh_q;
`else
    logic          unused_type;
    assign unused_type = ^bus.sq_data[4:2];
`endif

    logic [1:0]           dr, dc;
    logic signed [CW+1:0] trow, tcol;
    logic                 en, off;
    logic                 rd, wr, adv, inc;
    logic [CW-1:0]        wdist;
    logic                 wcap, wking;
    logic [CW:0]          im1;

    // Step codes: 01 = +1, 11 = -1, 00 = stay.
    function automatic logic signed [CW+1:0] step(
        input logic [CW-1:0] b,
        input logic [1:0]    d,
        input logic [CW:0]   n
    );
        logic signed [CW+1:0] bb, nn;
        bb = $signed({2'b00, b});
        nn = $signed({1'b0, n});
        unique case (d)
            2'b01:   step = bb + nn;
            2'b11:   step = bb - nn;
            default: step = bb;
        endcase
    endfunction

    always_comb begin
        dr = 2'b00;
        dc = 2'b00;
        unique case (k_q)
            3'd0: begin dr = 2'b11; dc = 2'b11; end
            3'd1: begin dr = 2'b11; dc = 2'b00; end
            3'd2: begin dr = 2'b11; dc = 2'b01; end
            3'd3: begin dr = 2'b00; dc = 2'b01; end
            3'd4: begin dr = 2'b01; dc = 2'b01; end
            3'd5: begin dr = 2'b01; dc = 2'b00; end
            3'd6: begin dr = 2'b01; dc = 2'b11; end
            3'd7: begin dr = 2'b00; dc = 2'b11; end
            default: ;
        endcase
    end

    assign trow = step(row_q, dr, i_q);
    assign tcol = step(col_q, dc, i_q);
    assign off  = trow[CW+1] || (trow > MAXC) || tcol[CW+1] || (tcol > MAXC);
    assign en   = k_q[0] ? mode_q[1] : mode_q[0];
    assign im1  = i_q - ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        rd      = 1'b0;
        wr      = 1'b0;
        adv     = 1'b0;
        inc     = 1'b0;
        wdist   = '0;
        wcap    = 1'b0;
        wking   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) state_d = CHECK;
            end
            CHECK: begin
                if (!en) begin
                    wr  = 1'b1;
                    adv = 1'b1;
                end else if (off) begin
                    wr    = 1'b1;
                    wdist = im1[CW-1:0];
                    adv   = 1'b1;
                end else begin
                    rd      = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!bus.sq_data[0]) begin
                    inc     = 1'b1;
                    state_d = CHECK;
                end else if (bus.sq_data[1] == color_q) begin
                    wr    = 1'b1;
                    wdist = im1[CW-1:0];
                    adv   = 1'b1;
                end else begin
                    wr    = 1'b1;
                    wdist = i_q[CW-1:0];
                    wcap  = 1'b1;
                    wking = (bus.sq_data[4:2] == 3'b110);
                    adv   = 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (adv) state_d = (k_q == 3'd7) ? DONE : CHECK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            lrow_q  <= '0;
            lcol_q  <= '0;
            color_q <= 1'b0;
            mode_q  <= 2'b00;
            k_q     <= 3'd0;
            i_q     <= ONE;
            cap_q   <= '0;
            for (int g = 0; g < 8; g++) dist_q[g] <= '0;
`ifdef SCAN_KING_HIT_EN
            kh_q    <= '0;
`endif
        end else begin
            if (state == IDLE && bus.req_valid) begin
                row_q   <= bus.req_row;
                col_q   <= bus.req_col;
                color_q <= bus.req_color;
                mode_q  <= bus.req_mode;
                k_q     <= 3'd0;
                i_q     <= ONE;
                cap_q   <= '0;
                for (int g = 0; g < 8; g++) dist_q[g] <= '0;
`ifdef SCAN_KING_HIT_EN
                kh_q    <= '0;
`endif
            end
            if (rd) begin
                lrow_q <= trow[CW-1:0];
                lcol_q <= tcol[CW-1:0];
            end
            if (inc) i_q <= i_q + ONE;
            if (wr) begin
                dist_q[k_q] <= wdist;
                cap_q[k_q]  <= wcap;
`ifdef SCAN_KING_HIT_EN
                kh_q[k_q]   <= wking;
`endif
            end
            if (adv) begin
                k_q <= k_q + 3'd1;
                i_q <= ONE;
            end
        end
    end

`ifndef SCAN_KING_HIT_EN
    logic unused_wking;
    assign unused_wking = wking;
`endif

    assign bus.req_ready   = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.sq_rd_en    = rd;
    assign bus.sq_row      = rd ? trow[CW-1:0] : lrow_q;
    assign bus.sq_col      = rd ? tcol[CW-1:0] : lcol_q;
    assign bus.res_capture = cap_q;
`ifdef SCAN_KING_HIT_EN
    assign bus.res_king_hit = kh_q;
`endif

    for (genvar g = 0; g < 8; g++) begin : g_dist
        assign bus.res_dist[g*CW +: CW] = dist_q[g];
    end
endmodule

// File: tb/tb_sliding_ray_scanner.sv
// Directed + random checks of sliding_ray_scanner against a ray-walk reference model.
// Build with SCAN_KING_HIT_EN defined to also exercise res_king_hit.
module tb_sliding_ray_scanner;
    localparam int N  = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sliding_ray_scanner_if #(.BOARD_N(N)) bus ();

    sliding_ray_scanner #(.BOARD_N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] board [N][N];

    // Board RAM with one cycle of read latency.
    always @(posedge clk)
        if (bus.sq_rd_en) bus.sq_data <= board[bus.sq_row][bus.sq_col];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*CW-1:0] pack(input int d [8]);
        logic [8*CW-1:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) p[k*CW +: CW] = CW'(d[k]);
        return p;
    endfunction

    // Walk every ray square by square over the board array.
    task automatic model(input int r0, input int c0, input logic colr,
                         input logic [1:0] m,
                         output logic [8*CW-1:0] ed, output logic [7:0] ec,
                         output logic [7:0] ek, output int cyc);
        int dr [8];
        int dc [8];
        int d  [8];
        dr = '{-1, -1, -1, 0, 1, 1, 1, 0};
        dc = '{-1, 0, 1, 1, 1, 0, -1, -1};
        ec = '0;
        ek = '0;
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            d[k] = 0;
            if (!((k % 2 == 0) ? m[0] : m[1])) begin
                cyc += 1;
                continue;
            end
            for (int i = 1; i <= N; i++) begin
                int r, c;
                logic [4:0] sq;
                r = r0 + dr[k] * i;
                c = c0 + dc[k] * i;
                if (r < 0 || r >= N || c < 0 || c >= N) begin
                    d[k] = i - 1;
                    cyc += 1;
                    break;
                end
                sq = board[r][c];
                cyc += 2;
                if (!sq[0]) continue;
                if (sq[1] == colr) begin
                    d[k] = i - 1;
                end else begin
                    d[k] = i;
                    ec[k] = 1'b1;
                    ek[k] = (sq[4:2] == 3'b110);
                end
                break;
            end
        end
        ed = pack(d);
    endtask

    task automatic clear_board();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                board[r][c] = '0;
    endtask

    task automatic start(input int r, input int c, input logic colr, input logic [1:0] m);
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_row   = CW'(r);
        bus.req_col   = CW'(c);
        bus.req_color = colr;
        bus.req_mode  = m;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic finish_res();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("req_ready_back", bus.req_ready, 1'b1);
        check("res_valid_drop", bus.res_valid, 1'b0);
    endtask

    task automatic run(input int r, input int c, input logic colr, input logic [1:0] m,
                       input string tag,
                       output logic [8*CW-1:0] gd, output logic [7:0] gc, output int lat);
        logic [8*CW-1:0] ed;
        logic [7:0] ec, ek;
        int cyc;
        model(r, c, colr, m, ed, ec, ek, cyc);
        start(r, c, colr, m);
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'(cyc));
        check({tag, "_dist"}, bus.res_dist, ed);
        check({tag, "_cap"}, bus.res_capture, ec);
`ifdef SCAN_KING_HIT_EN
        check({tag, "_king"}, bus.res_king_hit, ek);
`endif
        gd = bus.res_dist;
        gc = bus.res_capture;
        finish_res();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*CW-1:0] gd, snap_d;
        logic [7:0] gc, snap_c;
        int lat, n;

        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        bus.req_color = 1'b0;
        bus.req_mode  = 2'b00;
        bus.res_ready = 1'b0;
        clear_board();

        #12;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_sq_rd_en", bus.sq_rd_en, 1'b0);
        check("rst_sq_row", bus.sq_row, '0);
        check("rst_sq_col", bus.sq_col, '0);
        check("rst_res_dist", bus.res_dist, '0);
        check("rst_res_cap", bus.res_capture, '0);
`ifdef SCAN_KING_HIT_EN
        check("rst_king", bus.res_king_hit, '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Bishop on an empty board.
        run(3, 3, 1'b0, 2'b01, "bishop33", gd, gc, lat);
        check("bishop33_const_dist", gd, pack('{3, 0, 3, 0, 4, 0, 3, 0}));
        check("bishop33_const_lat", 64'(lat), 64'd34);
        check("bishop33_const_cap", gc, 8'h00);

        // Queen in the corner.
        run(0, 0, 1'b0, 2'b11, "queen00", gd, gc, lat);
        check("queen00_const_dist", gd, pack('{0, 0, 0, 7, 7, 7, 0, 0}));
        check("queen00_const_lat", 64'(lat), 64'd50);

        // Rook with own pawn right and opponent knight up.
        board[4][6] = 5'b001_0_1;
        board[1][4] = 5'b010_1_1;
        run(4, 4, 1'b0, 2'b10, "rook44", gd, gc, lat);
        check("rook44_const_dist", gd, pack('{0, 3, 0, 1, 0, 3, 0, 4}));
        check("rook44_const_cap", gc, 8'b0000_0010);

        // Mode 00 walks no rays.
        run(2, 5, 1'b1, 2'b00, "mode00", gd, gc, lat);
        check("mode00_const_lat", 64'(lat), 64'd8);

        // Reset while waiting on a board read.
        start(3, 3, 1'b0, 2'b11);
        n = 0;
        while (bus.sq_rd_en !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst_read_seen", bus.sq_rd_en, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", bus.req_ready, 1'b1);
        check("midrst_res_valid", bus.res_valid, 1'b0);
        check("midrst_sq_rd_en", bus.sq_rd_en, 1'b0);
        check("midrst_sq_row", bus.sq_row, '0);
        check("midrst_sq_col", bus.sq_col, '0);
        check("midrst_dist", bus.res_dist, '0);
        check("midrst_cap", bus.res_capture, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4, 4, 1'b0, 2'b10, "after_rst", gd, gc, lat);

        // Result held under backpressure; requests ignored.
        start(4, 4, 1'b1, 2'b11);
        wait_done(lat);
        check("bp_done", bus.res_valid, 1'b1);
        snap_d = bus.res_dist;
        snap_c = bus.res_capture;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            bus.req_valid = t[0];
            bus.req_row   = CW'($urandom_range(0, N - 1));
            bus.req_col   = CW'($urandom_range(0, N - 1));
            bus.req_mode  = 2'b11;
            @(posedge clk);
            #1;
            check("bp_res_valid", bus.res_valid, 1'b1);
            check("bp_req_ready", bus.req_ready, 1'b0);
            check("bp_dist", bus.res_dist, snap_d);
            check("bp_cap", bus.res_capture, snap_c);
        end
        bus.req_valid = 1'b0;
        finish_res();
        @(posedge clk);
        #1;
        check("bp_no_accept", bus.req_ready, 1'b1);

        // Random boards, positions, colours and modes.
        for (int t = 0; t < 25; t++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    board[r][c] = ($urandom_range(0, 99) < 30) ?
                        {3'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b1} : 5'b0;
            run($urandom_range(0, N - 1), $urandom_range(0, N - 1),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                "random", gd, gc, lat);
        end

`ifdef SCAN_KING_HIT_EN
        clear_board();
        board[2][2] = 5'b110_1_1;
        run(5, 5, 1'b0, 2'b01, "king", gd, gc, lat);
        check("king_const_ul", gd[0 +: CW], 3'd3);
        check("king_const_cap0", gc[0], 1'b1);
        check("king_const_hit", bus.res_king_hit, 8'b0000_0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
